// File: rtl/mem_ctrl_if.sv
// Requester and RAM-side signals of mem_ctrl, bundled for port connection.
// slave: the controller's view; master: the requesters' and RAM's view.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;

    logic        mem_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;

    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    modport slave (
        input  if_req, if_addr, mem_req, mem_wr_req, mem_addr, mem_len, mem_wdata, ram_din,
        output if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr
    );

    modport master (
        output if_req, if_addr, mem_req, mem_wr_req, mem_addr, mem_len, mem_wdata, ram_din,
        input  if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide RAM arbiter/sequencer shared by instruction fetch and the MEM stage.
// Define MEM_PREEMPT_EN to let a MEM request abort an in-flight IF fetch.
module mem_ctrl (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [2:0]  n_q, n_d;
    logic [2:0]  idx_q, idx_d;    // number of the coming edge, counted from acceptance (E0)
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] acc_q, acc_d;

    logic [31:0] ram_a_d;
    logic [7:0]  ram_dout_d;
    logic        ram_wr_d;
    logic [31:0] if_data_d, mem_rdata_d;
    logic        if_done_d, mem_done_d;
    logic        accept_mem, accept_if, preempt;

    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path through the case infers a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        n_d         = n_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        ram_a_d     = bus.ram_a;
        ram_dout_d  = bus.ram_dout;
        ram_wr_d    = 1'b0;
        if_data_d   = bus.if_data;
        mem_rdata_d = bus.mem_rdata;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        accept_mem  = 1'b0;
        accept_if   = 1'b0;
`ifdef MEM_PREEMPT_EN
        preempt     = (state_q == BUSY) && (owner_q == OWN_IF) && bus.mem_req;
`else
        preempt     = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.mem_req)
                    accept_mem = 1'b1;
                else if (bus.if_req)
                    accept_if = 1'b1;
            end
            BUSY: begin
                if (preempt) begin
                    accept_mem = 1'b1;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    ram_a_d = bus.ram_a + 32'd1;
                    if (wr_q) begin
                        // Byte i is presented after Ei and written by the RAM at E(i+1).
                        if (idx_q < n_q) begin
                            ram_wr_d   = 1'b1;
                            ram_dout_d = wdata_q[{idx_q[1:0], 3'b000} +: 8];
                        end else begin
                            state_d    = DONE;
                            mem_done_d = 1'b1;
                        end
                    end else begin
                        // Read data for the address driven after Ei arrives in time for E(i+2).
                        for (int b = 0; b < 4; b++) begin
                            if (idx_q == 3'(b + 2))
                                acc_d[8*b +: 8] = bus.ram_din;
                        end
                        if (idx_q == n_q + 3'd1) begin
                            state_d = DONE;
                            if (owner_q == OWN_IF) begin
                                if_done_d = 1'b1;
                                if_data_d = acc_d;
                            end else begin
                                mem_done_d  = 1'b1;
                                mem_rdata_d = acc_d;
                            end
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept_mem) begin
            state_d    = BUSY;
            owner_d    = OWN_MEM;
            wr_d       = bus.mem_wr_req;
            n_d        = len_to_n(bus.mem_len);
            idx_d      = 3'd1;
            wdata_d    = bus.mem_wdata;
            acc_d      = '0;
            ram_a_d    = bus.mem_addr;
            ram_dout_d = bus.mem_wdata[7:0];
            ram_wr_d   = bus.mem_wr_req;
        end else if (accept_if) begin
            state_d = BUSY;
            owner_d = OWN_IF;
            wr_d    = 1'b0;
            n_d     = 3'd4;
            idx_d   = 3'd1;
            acc_d   = '0;
            ram_a_d = bus.if_addr;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments; reset is synchronous and clears every output too.
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_IF;
            wr_q          <= 1'b0;
            n_q           <= 3'd0;
            idx_q         <= 3'd0;
            wdata_q       <= '0;
            acc_q         <= '0;
            bus.ram_a     <= '0;
            bus.ram_dout  <= '0;
            bus.ram_wr    <= 1'b0;
            bus.if_data   <= '0;
            bus.mem_rdata <= '0;
            bus.if_done   <= 1'b0;
            bus.mem_done  <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            wr_q          <= wr_d;
            n_q           <= n_d;
            idx_q         <= idx_d;
            wdata_q       <= wdata_d;
            acc_q         <= acc_d;
            bus.ram_a     <= ram_a_d;
            bus.ram_dout  <= ram_dout_d;
            bus.ram_wr    <= ram_wr_d;
            bus.if_data   <= if_data_d;
            bus.mem_rdata <= mem_rdata_d;
            bus.if_done   <= if_done_d;
            bus.mem_done  <= mem_done_d;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model, a reference memory image
// that predicts every done pulse and RAM write, and a monitor that checks them.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_ctrl_if bus();
    mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [31:0] data;
        bit          wr;
        int          lat;     // cycles from acceptance to done, -1 when contended
        int          start;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t if_q[$];
    exp_t mem_q[$];
    wr_t  wr_q[$];

    logic [7:0] ram_mem   [logic [31:0]];
    logic [7:0] model_mem [logic [31:0]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int if_done_cyc = 0;
    int mem_done_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return init_byte(a);
    endfunction

    // Reference: little-endian gather of n bytes, address wrapping mod 2^32.
    function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = model_rd(addr + 32'(i));
        return r;
    endfunction

    function automatic int len_bytes(input logic [1:0] len);
        if (len == 2'b00) return 1;
        if (len == 2'b01) return 2;
        return 4;
    endfunction

    // Synchronous byte RAM: samples address/write at the edge, read data follows it.
    always @(posedge clk) begin
        if (bus.ram_wr === 1'b1) ram_mem[bus.ram_a] = bus.ram_dout;
        bus.ram_din <= ram_rd(bus.ram_a);
    end

    // Monitor: every done pulse and every RAM write must match a queued prediction.
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (bus.if_done === 1'b1) begin
            if_done_cyc = cyc;
            if (if_q.size() == 0) begin
                check("if_done_unexpected", 32'd1, 32'd0);
            end else begin
                e = if_q.pop_front();
                check("if_data", bus.if_data, e.data);
                if (e.lat >= 0) check("if_latency", 32'(cyc - e.start), 32'(e.lat + 1));
            end
        end
        if (bus.mem_done === 1'b1) begin
            mem_done_cyc = cyc;
            if (mem_q.size() == 0) begin
                check("mem_done_unexpected", 32'd1, 32'd0);
            end else begin
                e = mem_q.pop_front();
                if (!e.wr) check("mem_rdata", bus.mem_rdata, e.data);
                if (e.lat >= 0) check("mem_latency", 32'(cyc - e.start), 32'(e.lat + 1));
            end
        end
        if (bus.ram_wr === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("ram_wr_unexpected", 32'd1, 32'd0);
            end else begin
                w = wr_q.pop_front();
                check("ram_wr_addr", bus.ram_a, w.a);
                check("ram_wr_data", {24'b0, bus.ram_dout}, {24'b0, w.d});
            end
        end
    end

    // All driver tasks start and end #1 after a rising edge.
    task automatic wait_if_done();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.if_done !== 1'b1 && k < 200);
        if (bus.if_done !== 1'b1) check("if_done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_done();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.mem_done !== 1'b1 && k < 200);
        if (bus.mem_done !== 1'b1) check("mem_done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic if_fetch(input logic [31:0] addr, input bit chk_lat);
        exp_t e;
        e.data  = ref_read(addr, 4);
        e.wr    = 1'b0;
        e.lat   = chk_lat ? 5 : -1;
        e.start = cyc;
        if_q.push_back(e);
        bus.if_addr = addr;
        bus.if_req  = 1'b1;
        wait_if_done();
        bus.if_req  = 1'b0;
    endtask

    task automatic mem_access(input bit wr, input logic [31:0] addr, input logic [1:0] len,
                              input logic [31:0] wdata, input bit chk_lat);
        exp_t e;
        wr_t  w;
        int   n = len_bytes(len);
        e.wr    = wr;
        e.data  = wr ? 32'd0 : ref_read(addr, n);
        e.lat   = chk_lat ? (wr ? n : n + 1) : -1;
        e.start = cyc;
        if (wr) begin
            for (int i = 0; i < n; i++) begin
                w.a = addr + 32'(i);
                w.d = wdata[8*i +: 8];
                wr_q.push_back(w);
                model_mem[w.a] = w.d;
            end
        end
        mem_q.push_back(e);
        bus.mem_wr_req = wr;
        bus.mem_addr   = addr;
        bus.mem_len    = len;
        bus.mem_wdata  = wdata;
        bus.mem_req    = 1'b1;
        wait_mem_done();
        bus.mem_req    = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_ram_a", bus.ram_a, 32'd0);
        check("rst_ram_dout", {24'b0, bus.ram_dout}, 32'd0);
        check("rst_ram_wr", {31'b0, bus.ram_wr}, 32'd0);
        check("rst_if_done", {31'b0, bus.if_done}, 32'd0);
        check("rst_mem_done", {31'b0, bus.mem_done}, 32'd0);
        check("rst_if_data", bus.if_data, 32'd0);
        check("rst_mem_rdata", bus.mem_rdata, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [7:0] prog [4];
        bit         preempt_lat;
        logic [31:0] a, d;
        prog = '{8'h13, 8'h05, 8'h50, 8'h00};
        for (int i = 0; i < 4; i++) begin
            ram_mem[32'h100 + 32'(i)]   = prog[i];
            model_mem[32'h100 + 32'(i)] = prog[i];
        end

        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_req = 1'b0; bus.mem_wr_req = 1'b0; bus.mem_addr = '0;
        bus.mem_len = 2'b00; bus.mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;

        // Directed cases
        if_fetch(32'h100, 1'b1);
        check("fetch_value_model", ref_read(32'h100, 4), 32'h00500513);
        mem_access(1'b1, 32'h2000, 2'b01, 32'hDEADBEEF, 1'b1);
        mem_access(1'b0, 32'h2001, 2'b00, 32'h0, 1'b1);
        mem_access(1'b0, 32'h2000, 2'b11, 32'h0, 1'b1);

        // Simultaneous requests: MEM first, IF after MEM's DONE cycle, fetch wraps.
        fork
            mem_access(1'b0, 32'h2000, 2'b11, 32'h0, 1'b1);
            if_fetch(32'hFFFF_FFFE, 1'b0);
        join
        check("arb_if_after_mem", 32'(if_done_cyc), 32'(mem_done_cyc + 7));

        // mem_req raised two cycles into a fetch.
`ifdef MEM_PREEMPT_EN
        preempt_lat = 1'b1;
`else
        preempt_lat = 1'b0;
`endif
        fork
            if_fetch(32'h104, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                mem_access(1'b0, 32'h2010, 2'b11, 32'h0, preempt_lat);
            end
        join
`ifdef MEM_PREEMPT_EN
        check("preempt_if_after_mem", 32'(if_done_cyc), 32'(mem_done_cyc + 7));
`else
        check("nopreempt_mem_after_if", 32'(mem_done_cyc), 32'(if_done_cyc + 7));
`endif

        // Reset after byte 1 of a word store: bytes 0 and 1 land, no done pulse.
        for (int i = 0; i < 2; i++) begin
            wr_t w;
            w.a = 32'h2040 + 32'(i);
            w.d = 8'hA0 + 8'(i);
            wr_q.push_back(w);
            model_mem[w.a] = w.d;
        end
        bus.mem_wr_req = 1'b1; bus.mem_addr = 32'h2040; bus.mem_len = 2'b11;
        bus.mem_wdata = 32'hA3A2A1A0; bus.mem_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; bus.mem_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        if_fetch(32'h100, 1'b1);
        mem_access(1'b0, 32'h2040, 2'b11, 32'h0, 1'b1);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            int op = int'($urandom_range(0, 4));
            a = 32'h2000 + 32'($urandom_range(0, 252));
            d = $urandom;
            case (op)
                0, 1: mem_access(1'b1, a, 2'($urandom_range(0, 3)), d, 1'b1);
                2:    mem_access(1'b0, ($urandom_range(0, 1) != 0) ? a : 32'h100 + 32'($urandom_range(0, 8)),
                                 2'($urandom_range(0, 3)), 32'h0, 1'b1);
                3:    if_fetch(($urandom_range(0, 1) != 0) ? 32'h100 + 32'($urandom_range(0, 8))
                                                           : 32'hFFFF_FFF9 + 32'($urandom_range(0, 7)), 1'b1);
                default: begin
                    int dly = int'($urandom_range(0, 6));
                    bit wr  = ($urandom_range(0, 1) != 0);
                    logic [1:0] len = 2'($urandom_range(0, 3));
                    fork
                        if_fetch(32'h100 + 32'($urandom_range(0, 8)), 1'b0);
                        begin
                            repeat (dly) @(posedge clk);
                            if (dly > 0) #1;
                            mem_access(wr, a, len, d, 1'b0);
                        end
                    join
                end
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        repeat (8) @(posedge clk);
        check("if_q_drained", 32'(if_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
